pyfive_wb_initiator: RTL and testbench

Wishbone classic single-transfer bus master for the PyFive fabric. It sits opposite the Wishbone slave ports of `pyfive_top` and turns a valid/ready request stream into one Wishbone read or write cycle per request. Each completed cycle returns one response on a valid/ready stream. A response is produced whether the cycle ends in an acknowledge or in a timeout abort.

---
 rtl/pyfive_wb_initiator.sv | 98 +++++++++
 tb/tb_pyfive_wb_initiator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pyfive_wb_initiator.sv
// Wishbone classic single-transfer master: one request in, one bus cycle out,
// one response back (acknowledged data or timeout abort).
module pyfive_wb_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;

  assign req_ready = (state == IDLE);

  // NOTE: all state updates use <= so every branch sees pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wbm_we_o  <= req_we;
            wbm_adr_o <= req_adr;
            wbm_dat_o <= req_dat;
            wbm_sel_o <= req_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cnt       <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            state     <= RESP;
          end else if (TO_EN && cnt == LIMIT) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_dat   <= '0;
            state     <= RESP;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pyfive_wb_initiator.sv
// Directed self-checking bench for pyfive_wb_initiator (TIMEOUT = 8).
module tb_pyfive_wb_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = '0;
  logic        ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  pyfive_wb_initiator #(.TIMEOUT(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_dat  (req_dat),
    .req_sel  (req_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(dat_o),
    .wbm_dat_i(dat_i),
    .wbm_ack_i(ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    req_valid = 1'b1;
    req_we    = w;
    req_adr   = a;
    req_dat   = d;
    req_sel   = s;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check("cyc_after_accept", {31'b0, cyc}, 32'd1);
    check("stb_after_accept", {31'b0, stb}, 32'd1);
    check("req_ready_busy", {31'b0, req_ready}, 32'd0);
  endtask

  initial begin
    step();
    step();
    check("rst_cyc", {31'b0, cyc}, 32'd0);
    check("rst_stb", {31'b0, stb}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_adr", adr, 32'd0);
    rst = 1'b0;
    step();
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Zero-wait read
    issue(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    check("rd_adr", adr, 32'h3000_0004);
    check("rd_we", {31'b0, we}, 32'd0);
    ack = 1'b1; dat_i = 32'hA5A5_1234;
    step();
    ack = 1'b0;
    check("rd_cyc_low", {31'b0, cyc}, 32'd0);
    check("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rd_rsp_dat", rsp_dat, 32'hA5A5_1234);
    check("rd_rsp_err", {31'b0, rsp_err}, 32'd0);
    step();
    check("rd_rsp_done", {31'b0, rsp_valid}, 32'd0);
    check("rd_req_ready_again", {31'b0, req_ready}, 32'd1);

    // Write with 3 wait states
    dat_i = 32'h1111_1111;
    issue(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      check("wr_cyc", {31'b0, cyc}, 32'd1);
      check("wr_adr", adr, 32'h3000_0010);
      check("wr_dat", dat_o, 32'hDEAD_BEEF);
      check("wr_sel", {28'b0, sel}, 32'h3);
      check("wr_we", {31'b0, we}, 32'd1);
      check("wr_no_rsp", {31'b0, rsp_valid}, 32'd0);
      if (i == 3) ack = 1'b1;
      step();
    end
    ack = 1'b0;
    check("wr_cyc_low", {31'b0, cyc}, 32'd0);
    check("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("wr_rsp_dat", rsp_dat, 32'd0);
    check("wr_rsp_err", {31'b0, rsp_err}, 32'd0);
    step();
    check("wr_rsp_done", {31'b0, rsp_valid}, 32'd0);
    check("wr_dat_kept", dat_o, 32'hDEAD_BEEF);

    // Timeout: no ack for 8 cycles
    dat_i = 32'h5555_AAAA;
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      check("to_cyc_high", {31'b0, cyc}, 32'd1);
      step();
    end
    check("to_cyc_low", {31'b0, cyc}, 32'd0);
    check("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("to_rsp_err", {31'b0, rsp_err}, 32'd1);
    check("to_rsp_dat", rsp_dat, 32'd0);
    step();
    check("to_rsp_done", {31'b0, rsp_valid}, 32'd0);
    check("to_err_clr", {31'b0, rsp_err}, 32'd0);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("late_ack_cyc", {31'b0, cyc}, 32'd0);
    check("late_ack_rsp", {31'b0, rsp_valid}, 32'd0);
    check("late_ack_idle", {31'b0, req_ready}, 32'd1);

    // Ack arriving on the timeout edge
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      check("race_cyc_high", {31'b0, cyc}, 32'd1);
      if (i == 7) begin ack = 1'b1; dat_i = 32'hCAFE_F00D; end
      step();
    end
    ack = 1'b0;
    check("race_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("race_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("race_rsp_dat", rsp_dat, 32'hCAFE_F00D);
    step();

    // Response backpressure with a second request pending
    rsp_ready = 1'b0;
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    ack = 1'b1; dat_i = 32'h1234_5678;
    step();
    ack = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0044; req_sel = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_dat", rsp_dat, 32'h1234_5678);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      check("bp_cyc", {31'b0, cyc}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    check("bp_still_valid", {31'b0, rsp_valid}, 32'd1);
    step();
    check("bp_rsp_done", {31'b0, rsp_valid}, 32'd0);
    check("bp_req_ready_up", {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check("bp_second_cyc", {31'b0, cyc}, 32'd1);
    check("bp_second_adr", adr, 32'h3000_0044);
    ack = 1'b1; dat_i = 32'h0BAD_F00D;
    step();
    ack = 1'b0;
    check("bp_second_dat", rsp_dat, 32'h0BAD_F00D);
    step();

    // Reset during a BUS wait state
    issue(1'b1, 32'h3000_0050, 32'h7777_8888, 4'hC);
    step();
    check("mr_cyc_wait", {31'b0, cyc}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_cyc", {31'b0, cyc}, 32'd0);
    check("mr_stb", {31'b0, stb}, 32'd0);
    check("mr_we", {31'b0, we}, 32'd0);
    check("mr_sel", {28'b0, sel}, 32'd0);
    check("mr_adr", adr, 32'd0);
    check("mr_dat_o", dat_o, 32'd0);
    check("mr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mr_rsp_dat", rsp_dat, 32'd0);
    check("mr_req_ready", {31'b0, req_ready}, 32'd1);
    step();
    check("mr_no_rsp", {31'b0, rsp_valid}, 32'd0);
    issue(1'b0, 32'h3000_0060, 32'h0, 4'hF);
    ack = 1'b1; dat_i = 32'h600D_D00D;
    step();
    ack = 1'b0;
    check("mr_after_valid", {31'b0, rsp_valid}, 32'd1);
    check("mr_after_dat", rsp_dat, 32'h600D_D00D);
    step();
    check("mr_after_idle", {31'b0, req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
